// File: rtl/mem_port_arbiter.sv
// Instruction/data port arbiter in front of one multi-cycle unified memory.
// Accesses are serialised by a four-state FSM (Idle -> Issue -> Wait -> Resp).
// Each access issues a one-cycle m_en strobe and waits for m_valid. If
// m_valid does not arrive, a timeout sets a sticky err flag. Each access ends
// with a one-cycle ack to the port that won it.
// Optional feature: define ARB_RR_EN for round-robin arbitration when both
// ports request together. By default the data port has fixed priority.
module mem_port_arbiter #(
  parameter int unsigned AWIDTH  = 16,
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  // Instruction-fetch port
  input  logic              i_req,
  input  logic [AWIDTH-1:0] i_addr,
  output logic [DWIDTH-1:0] i_rdata,
  output logic              i_ack,
  // Data (load/store) port
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              d_ack,
  // Unified memory interface
  output logic              m_en,
  output logic              m_wr,
  output logic [AWIDTH-1:0] m_addr,
  output logic [DWIDTH-1:0] m_wdata,
  input  logic [DWIDTH-1:0] m_rdata,
  input  logic              m_valid,
  // Status
  output logic              err,
  output logic              busy
);

  // Wide enough to hold TIMEOUT itself; Wait is left at TIMEOUT-1 so it never wraps.
  localparam int unsigned    CntW    = $clog2(TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              grant_data_q;  // winner of the access in flight: 1 = data port
  logic              last_data_q;   // last_grant: 1 = data port, 0 = instruction port
  logic              m_en_q;
  logic              m_wr_q;
  logic [AWIDTH-1:0] m_addr_q;
  logic [DWIDTH-1:0] m_wdata_q;
  logic [DWIDTH-1:0] i_rdata_q;
  logic [DWIDTH-1:0] d_rdata_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic              err_q;
  logic              busy_q;
  logic              pick_data;

  // Winner selection among the ports requesting in Idle.
  always_comb begin
    pick_data = d_req;
`ifdef ARB_RR_EN
    if (d_req && i_req) begin
      pick_data = ~last_data_q;
    end
`endif
  end

`ifndef ARB_RR_EN
  // last_grant is still tracked without round-robin, but nothing reads it.
  logic unused_last_data;
  assign unused_last_data = last_data_q;
`endif

  // Access sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      grant_data_q <= 1'b0;
      last_data_q  <= 1'b0;
      m_en_q       <= 1'b0;
      m_wr_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      m_en_q  <= 1'b0;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_req || d_req) begin
            grant_data_q <= pick_data;
            last_data_q  <= pick_data;
            m_addr_q     <= pick_data ? d_addr : i_addr;
            m_wr_q       <= pick_data & d_wr;
            m_wdata_q    <= pick_data ? d_wdata : '0;
            m_en_q       <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (m_valid) begin
            // A completion in the final Wait cycle still counts as a success.
            if (grant_data_q) begin
              if (!m_wr_q) begin
                d_rdata_q <= m_rdata;
              end
              d_ack_q <= 1'b1;
            end else begin
              i_rdata_q <= m_rdata;
              i_ack_q   <= 1'b1;
            end
            state_q <= StResp;
          end else if (cnt_q == CntLast) begin
            err_q <= 1'b1;
            if (grant_data_q) begin
              d_rdata_q <= '0;
              d_ack_q   <= 1'b1;
            end else begin
              i_rdata_q <= '0;
              i_ack_q   <= 1'b1;
            end
            state_q <= StResp;
          end
        end
        StResp: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign m_en    = m_en_q;
  assign m_wr    = m_wr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It has three parts:
// - A memory model whose latency is set by the bench.
// - A reference model that predicts every output from grant time, memory
//   latency and timeout.
// - A compare process on the falling clock edge, plus directed scenarios with
//   hand-computed literal expectations.
module tb_mem_port_arbiter;

  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [15:0] m_rdata = 16'h0000;
  logic        m_valid = 1'b0;
  logic        i_ack, d_ack, m_en, m_wr, err, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AWIDTH(16), .DWIDTH(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_en(m_en), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_valid(m_valid),
    .err(err), .busy(busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // ---------------- memory environment ----------------
  logic [15:0] env_mem [bit [15:0]];
  int          mem_lat  = 1;
  bit          mem_hang = 1'b0;
  int          stray_at = -1;
  bit          pend     = 1'b0;
  int          due      = 0;
  logic [15:0] p_addr;
  bit          p_wr;

  function automatic logic [15:0] env_rd(input logic [15:0] a);
    return env_mem.exists(a) ? env_mem[a] : (a ^ 16'h5A5A);
  endfunction

  // Responds L cycles after the m_en cycle; drives inputs 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    m_valid = 1'b0;
    m_rdata = 16'h0000;
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend && cyc == due) begin
        m_valid = 1'b1;
        m_rdata = p_wr ? 16'hBEEF : env_rd(p_addr);
        pend    = 1'b0;
      end else if (cyc == stray_at) begin
        m_valid = 1'b1;
        m_rdata = 16'h0BAD;
      end
      if (m_en) begin
        if (m_wr) env_mem[m_addr] = m_wdata;
        if (!mem_hang) begin
          pend   = 1'b1;
          due    = cyc + mem_lat;
          p_addr = m_addr;
          p_wr   = m_wr;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [bit [15:0]];
  bit          r_act = 1'b0, r_data = 1'b0, r_ok = 1'b0, r_wr = 1'b0, r_err = 1'b0;
  int          r_t0 = 0, r_tack = 0;
  logic [15:0] r_addr = '0, r_wdata = '0, r_irdata = '0, r_drdata = '0;
`ifdef ARB_RR_EN
  bit          r_last_d = 1'b0;
`endif

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'h5A5A);
  endfunction

  // An access granted at the end of cycle t0 issues in t0+1 and acks in t0+2+L.
  // If L exceeds TIMEOUT it acks in t0+2+TIMEOUT with an error instead.
  always @(posedge clk) begin
    if (rst) begin
      r_act = 0; r_err = 0; r_irdata = '0; r_drdata = '0;
      r_addr = '0; r_wdata = '0; r_wr = 0;
`ifdef ARB_RR_EN
      r_last_d = 0;
`endif
    end else if (!r_act) begin
      if (i_req || d_req) begin
        r_data = d_req;
`ifdef ARB_RR_EN
        if (i_req && d_req) r_data = !r_last_d;
        r_last_d = r_data;
`endif
        r_addr  = r_data ? d_addr : i_addr;
        r_wr    = r_data && d_wr;
        r_wdata = r_data ? d_wdata : 16'h0000;
        r_ok    = !mem_hang && mem_lat <= TMO;
        r_t0    = cyc;
        r_tack  = cyc + 2 + (r_ok ? mem_lat : TMO);
        r_act   = 1;
      end
    end else begin
      if (cyc == r_tack - 1) begin
        if (r_ok) begin
          if (r_wr) ref_mem[r_addr] = r_wdata;
          else if (r_data) r_drdata = ref_rd(r_addr);
          else r_irdata = ref_rd(r_addr);
        end else begin
          r_err = 1;
          if (r_data) r_drdata = '0;
          else r_irdata = '0;
        end
      end
      if (cyc == r_tack) r_act = 0;
    end
    cyc++;
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy",    busy,    rst ? 0 : 32'(r_act));
      chk("m_en",    m_en,    rst ? 0 : 32'(r_act && cyc == r_t0 + 1));
      chk("i_ack",   i_ack,   rst ? 0 : 32'(r_act && cyc == r_tack && !r_data));
      chk("d_ack",   d_ack,   rst ? 0 : 32'(r_act && cyc == r_tack && r_data));
      chk("i_rdata", i_rdata, rst ? 0 : 32'(r_irdata));
      chk("d_rdata", d_rdata, rst ? 0 : 32'(r_drdata));
      chk("err",     err,     rst ? 0 : 32'(r_err));
      chk("m_addr",  m_addr,  rst ? 0 : 32'(r_addr));
      chk("m_wr",    m_wr,    rst ? 0 : 32'(r_wr));
      chk("m_wdata", m_wdata, rst ? 0 : 32'(r_wdata));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One access on one port; records issue cycle, ack cycle and issued fields.
  task automatic access(input bit is_d, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, output int c0, output int c_en,
                        output int c_ack, output logic [15:0] rd, output logic en_wr,
                        output logic [15:0] en_addr, output logic [15:0] en_wdata,
                        output bit other_ack);
    tick();
    if (is_d) begin d_req = 1; d_wr = wr; d_addr = a; d_wdata = wd; end
    else begin i_req = 1; i_addr = a; end
    c0 = cyc; c_en = -1; c_ack = -1; rd = '0;
    en_wr = 0; en_addr = '0; en_wdata = '0; other_ack = 0;
    for (int k = 0; k < 60 && c_ack < 0; k++) begin
      tick();
      if (m_en && c_en < 0) begin c_en = cyc; en_wr = m_wr; en_addr = m_addr; en_wdata = m_wdata; end
      if (is_d ? i_ack : d_ack) other_ack = 1;
      if (is_d ? d_ack : i_ack) begin c_ack = cyc; rd = is_d ? d_rdata : i_rdata; end
    end
    i_req = 0; d_req = 0;
  endtask

  int c0, c_en, c_ack, ai, ad, e1, e2, a1, a2, nack;
  logic [15:0] rd, en_addr, en_wdata, e2_addr;
  logic en_wr;
  bit other;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
    env_mem[16'h0010] = 16'hA5A5;
    ref_mem[16'h0010] = 16'hA5A5;
    rst = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_m_en", m_en, 0);
    chk("reset_err", err, 0);
    chk("reset_i_rdata", i_rdata, 0);

    // Single fetch, L=1.
    mem_lat = 1;
    access(0, 0, 16'h0010, 16'h0, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("fetch_m_en_cycle", c_en - c0, 1);
    chk("fetch_m_addr", en_addr, 16'h0010);
    chk("fetch_m_wr", en_wr, 0);
    chk("fetch_ack_cycle", c_ack - c0, 3);
    chk("fetch_rdata", rd, 16'hA5A5);
    chk("fetch_no_d_ack", other, 0);

    // Load, then store with L=4 (load data must survive), then reload.
    access(1, 0, 16'h8000, 16'h0, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("load_rdata", rd, 16'hDA5A);
    mem_lat = 4;
    access(1, 1, 16'h8000, 16'h1234, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("store_m_en_cycle", c_en - c0, 1);
    chk("store_m_wr", en_wr, 1);
    chk("store_m_wdata", en_wdata, 16'h1234);
    chk("store_ack_cycle", c_ack - c0, 6);
    chk("store_rdata_kept", rd, 16'hDA5A);
    chk("store_no_i_ack", other, 0);
    mem_lat = 1;
    access(1, 0, 16'h8000, 16'h0, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("reload_rdata", rd, 16'h1234);

    // Stray m_valid while idle must be ignored.
    stray_at = cyc + 2;
    repeat (4) tick();
    stray_at = -1;
    chk("stray_busy", busy, 0);
    chk("stray_d_rdata", d_rdata, 16'h1234);

    // Contention after reset, L=1: data first, instruction four cycles later.
    do_reset();
    tick();
    i_req = 1; i_addr = 16'h0010; d_req = 1; d_wr = 0; d_addr = 16'h0100;
    c0 = cyc; ai = -1; ad = -1;
    for (int k = 0; k < 40 && (ai < 0 || ad < 0); k++) begin
      tick();
      if (d_ack && ad < 0) begin ad = cyc; d_req = 0; chk("cont_d_rdata", d_rdata, 16'h5B5A); end
      if (i_ack && ai < 0) begin ai = cyc; i_req = 0; chk("cont_i_rdata", i_rdata, 16'hA5A5); end
    end
    i_req = 0; d_req = 0;
    chk("cont_d_ack_cycle", ad - c0, 3);
    chk("cont_i_ack_cycle", ai - c0, 7);

    // m_valid in the last Wait cycle (L=TIMEOUT) still succeeds.
    mem_lat = TMO;
    access(0, 0, 16'h0022, 16'h0, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("edge_ack_cycle", c_ack - c0, 34);
    chk("edge_rdata", rd, 16'h5A78);
    chk("edge_err", err, 0);

    // Memory never answers: timeout.
    mem_hang = 1;
    access(0, 0, 16'h0010, 16'h0, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("tmo_ack_cycle", c_ack - c0, 34);
    chk("tmo_rdata", rd, 16'h0000);
    chk("tmo_err", err, 1);
    mem_hang = 0;
    mem_lat = 1;
    access(0, 0, 16'h0010, 16'h0, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("post_tmo_rdata", rd, 16'hA5A5);
    chk("post_tmo_err_sticky", err, 1);

    // Back-to-back fetches with i_req held through the first ack.
    tick();
    i_req = 1; i_addr = 16'h0040;
    e1 = -1; e2 = -1; a1 = -1; a2 = -1; e2_addr = '0; rd = '0;
    for (int k = 0; k < 40 && a2 < 0; k++) begin
      tick();
      if (m_en) begin
        if (e1 < 0) e1 = cyc;
        else if (e2 < 0) begin e2 = cyc; e2_addr = m_addr; end
      end
      if (i_ack) begin
        if (a1 < 0) begin a1 = cyc; i_addr = 16'h0041; end
        else begin a2 = cyc; rd = i_rdata; i_req = 0; end
      end
    end
    i_req = 0;
    chk("b2b_m_en_gap", e2 - e1, 4);
    chk("b2b_second_addr", e2_addr, 16'h0041);
    chk("b2b_ack_gap", a2 - a1, 4);
    chk("b2b_second_rdata", rd, 16'h5A1B);

    // Reset in the second Wait cycle aborts the access.
    mem_lat = 10;
    tick();
    i_req = 1; i_addr = 16'h0030;
    tick(); tick(); tick();
    rst = 1; i_req = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_m_en", m_en, 0);
    tick();
    tick();
    rst = 0;
    nack = 0;
    repeat (15) begin
      tick();
      if (i_ack || d_ack) nack++;
    end
    chk("rst_mid_no_ack", nack, 0);
    mem_lat = 1;
    access(0, 0, 16'h0030, 16'h0, c0, c_en, c_ack, rd, en_wr, en_addr, en_wdata, other);
    chk("rst_fresh_ack_cycle", c_ack - c0, 3);
    chk("rst_fresh_rdata", rd, 16'h5A6A);
    chk("rst_fresh_err", err, 0);

    repeat (2) tick();
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle unified memory between the instruction-fetch port and the data (load/store) port of the processor.
- A 4-state FSM serialises accesses, drives the memory request interface, returns read data and one-cycle acks to the winning requester, and flags memory timeouts.
- Sits between the fetch/memory stages and the unified memory model; replaces the separate instruction and data memories once the memory goes multi-cycle.

Parameters:
- AWIDTH, 16, address width
- DWIDTH, 16, data width
- TIMEOUT, 32, max cycles waited in WAIT for m_valid before error (>=2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_req  in  1  instruction read request; held until i_ack
- i_addr  in  AWIDTH  instruction address; stable while i_req
- i_rdata  out  DWIDTH  instruction read data; valid with i_ack
- i_ack  out  1  one-cycle completion pulse to fetch port
- d_req  in  1  data request; held until d_ack
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  AWIDTH  data address
- d_wdata  in  DWIDTH  store data
- d_rdata  out  DWIDTH  load data; valid with d_ack
- d_ack  out  1  one-cycle completion pulse to data port
- m_en  out  1  memory request strobe, one cycle per access
- m_wr  out  1  memory write enable, qualified by m_en
- m_addr  out  AWIDTH  memory address
- m_wdata  out  DWIDTH  memory write data
- m_rdata  in  DWIDTH  memory read data, valid with m_valid
- m_valid  in  1  memory completion, reads and writes
- err  out  1  sticky timeout flag
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state IDLE, all outputs 0, i_rdata/d_rdata 0, timeout counter 0, last_grant = instruction port. Reset mid-access aborts it: no ack issued, m_en low.
- States:
  - IDLE: if d_req|i_req, pick winner, register m_addr/m_wdata/m_wr from the winner's port (instruction port: m_wr=0, m_wdata=0), update last_grant, go ISSUE. Otherwise stay.
  - ISSUE: m_en=1 for exactly this cycle; counter cleared; go WAIT.
  - WAIT: counter increments each cycle.
    - m_valid=1: capture m_rdata into the winner's rdata register (stores leave it unchanged); go RESP.
    - Else if counter==TIMEOUT-1: set err; load winner's rdata with 0; go RESP.
    - m_valid and timeout in the same cycle: m_valid wins, err not set.
  - RESP: winner's ack=1 for this cycle only; go IDLE.
- Arbitration, fixed priority: data port beats instruction port when both request in IDLE.
- Latency: request seen in IDLE at cycle 0 → m_en at cycle 1 → with memory latency L (m_valid at cycle 1+L) → ack at cycle 2+L. Minimum, L=1: ack at cycle 3.
- Requester handshake:
  - req and fields must stay stable until ack.
  - Requester may hold req high in the cycle after ack to start a new access; the arbiter re-samples in IDLE.
  - Requests during ISSUE/WAIT/RESP are not sampled; the losing requester simply waits.
- m_valid outside WAIT is ignored.
- m_addr/m_wr/m_wdata hold their values from IDLE through RESP.
- err is cleared only by rst.
- rdata registers hold their value until the next completion on that port.
- Counter width: clog2(TIMEOUT)+1; no wrap, because the FSM leaves WAIT at TIMEOUT-1.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: when both requests are present in IDLE, grant the port not in last_grant (round-robin). A single requester always wins.
- Undefined: fixed data-over-instruction priority; last_grant is still maintained but unused.

Test Plan:
- Single fetch: i_req=1, i_addr=16'h0010, memory L=1 returns 16'hA5A5 → m_en at cycle 1 with m_addr=16'h0010, m_wr=0; i_ack at cycle 3 with i_rdata=16'hA5A5; d_ack stays 0.
- Store: d_req=1, d_wr=1, d_addr=16'h8000, d_wdata=16'h1234, L=4 → m_en=1, m_wr=1, m_wdata=16'h1234 at cycle 1; d_ack at cycle 6; d_rdata unchanged.
- Contention: i_req and d_req both held high for 2 accesses, L=1 →
  - Fixed priority: d_ack at cycle 3, i_ack at cycle 7.
  - ARB_RR_EN defined, after reset: first grant to data (last_grant=instruction), then instruction.
- Timeout: TIMEOUT=32, memory never asserts m_valid → i_ack at cycle 34 with i_rdata=0, err=1 and remaining 1 after later successful accesses.
- Back-to-back: fetch port holds i_req high through its ack with a new address, L=1 → second m_en exactly 4 cycles after the first.
- Reset mid-WAIT: assert rst at cycle 2 of WAIT → busy=0, m_en=0, no ack; a fresh request after deassertion completes normally.
